// File: rtl/alu_pkg.sv
// ALU definitions shared by the arbiter and the execute stage.
// Function codes and arbiter FSM state encodings.
package alu_pkg;

   typedef logic [1:0] alu_fn_t;

   localparam alu_fn_t FN_ADD = 2'd0;
   localparam alu_fn_t FN_SUB = 2'd1;
   localparam alu_fn_t FN_AND = 2'd2;
   localparam alu_fn_t FN_XOR = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_64bit.sv
// Combinational 64-bit ALU: add, sub, and, xor.
// Produces the signed-overflow flag for add/sub only.
module alu_64bit
   import alu_pkg::*;
(
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  alu_fn_t     fn,
   output logic [63:0] out,
   output logic        of
);

   logic [63:0] sum;
   logic [63:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   // select result and overflow by function code
   always_comb begin
      out = '0;
      of  = 1'b0;
      unique case (fn)
         FN_ADD: begin
            out = sum;
            of  = (a[63] == b[63]) && (sum[63] != a[63]);
         end
         FN_SUB: begin
            out = diff;
            of  = (a[63] != b[63]) && (diff[63] != a[63]);
         end
         FN_AND: out = a & b;
         FN_XOR: out = a ^ b;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 64-bit ALU between two requesters.
// One operation in flight: IDLE grants, EXEC computes, RESP holds result.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic [1:0]  req0_fn,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   input  logic [1:0]  req1_fn,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [63:0] resp_out,
   output logic [2:0]  resp_cc
);

   logic [1:0]  state;
   logic        last_grant;
   logic [63:0] a_q;
   logic [63:0] b_q;
   alu_fn_t     fn_q;
   logic        id_q;
   logic        g0;
   logic        g1;
   logic [63:0] alu_out;
   logic        alu_of;
   logic        zf;
   logic        sf;

   alu_64bit u_alu (
      .a   (a_q),
      .b   (b_q),
      .fn  (fn_q),
      .out (alu_out),
      .of  (alu_of)
   );

   assign zf = (alu_out == 64'd0);
   assign sf = alu_out[63];

   // grant: sole valid requester, else the one not granted last
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (state == ST_IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            g0 = last_grant;
            g1 = !last_grant;
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
      end
   end

   assign req0_ready = g0;
   assign req1_ready = g1;
   assign resp_valid = (state == ST_RESP);

   // FSM, operand capture and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         fn_q       <= FN_ADD;
         id_q       <= 1'b0;
         resp_out   <= '0;
         resp_cc    <= '0;
         resp_id    <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (g0 || g1) begin
                  a_q        <= g1 ? req1_a  : req0_a;
                  b_q        <= g1 ? req1_b  : req0_b;
                  fn_q       <= g1 ? req1_fn : req0_fn;
                  id_q       <= g1;
                  last_grant <= g1;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_out <= alu_out;
               resp_cc  <= {zf, sf, alu_of};
               resp_id  <= id_q;
               state    <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Inputs driven and outputs sampled just after the rising edge.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [63:0] req0_a, req0_b;
   logic [1:0]  req0_fn;
   logic        req1_valid, req1_ready;
   logic [63:0] req1_a, req1_b;
   logic [1:0]  req1_fn;
   logic        resp_valid, resp_ready, resp_id;
   logic [63:0] resp_out;
   logic [2:0]  resp_cc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_fn    (req0_fn),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_fn    (req1_fn),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_out   (resp_out),
      .resp_cc    (resp_cc)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // single-requester operation with bounded wait for ready
   task automatic do_op(input logic id, input logic [63:0] a,
                        input logic [63:0] b, input logic [1:0] fn,
                        input logic [63:0] eout, input logic [2:0] ecc,
                        input string tag);
      logic rdy;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fn = fn;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fn = fn;
      end
      #1;
      rdy = id ? req1_ready : req0_ready;
      for (int i = 0; i < 8 && !rdy; i++) begin
         step();
         rdy = id ? req1_ready : req0_ready;
      end
      chk({tag, "_ready"}, rdy, 1'b1);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk({tag, "_exec_nvalid"}, resp_valid, 1'b0);
      step();
      chk({tag, "_valid"}, resp_valid, 1'b1);
      chk({tag, "_out"}, resp_out, eout);
      chk({tag, "_cc"}, resp_cc, ecc);
      chk({tag, "_id"}, resp_id, id);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk({tag, "_idle_nvalid"}, resp_valid, 1'b0);
      chk({tag, "_out_hold"}, resp_out, eout);
   endtask

   initial begin
      logic exp_g;
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_fn = 2'd0;
      req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_fn = 2'd0;
      resp_ready = 1'b0;
      step();
      step();
      chk("rst_r0_ready", req0_ready, 1'b0);
      chk("rst_r1_ready", req1_ready, 1'b0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;
      chk("rst_valid", resp_valid, 1'b0);
      chk("rst_out", resp_out, 64'd0);
      chk("rst_cc", resp_cc, 3'b000);
      chk("rst_id", resp_id, 1'b0);

      // basic add with exact latency
      req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd7; req0_fn = 2'd0;
      #1;
      chk("add_ready0", req0_ready, 1'b1);
      chk("add_ready1", req1_ready, 1'b0);
      step();
      req0_valid = 1'b0;
      chk("add_exec", resp_valid, 1'b0);
      step();
      chk("add_valid", resp_valid, 1'b1);
      chk("add_out", resp_out, 64'd12);
      chk("add_cc", resp_cc, 3'b000);
      chk("add_id", resp_id, 1'b0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("add_done", resp_valid, 1'b0);

      do_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            2'd1, 64'h8000_0000_0000_0000, 3'b011, "sub_of");
      do_op(1'b1, 64'd3, 64'd3, 2'd1, 64'd0, 3'b100, "sub_zero");
      do_op(1'b0, 64'hF0F0, 64'hFF00, 2'd2, 64'hF000, 3'b000, "and");
      do_op(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0,
            64'h8000_0000_0000_0000, 3'b011, "add_of");

      // round robin with both requesters held valid
      rst = 1'b1;
      step();
      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd1; req0_fn = 2'd0;
      req1_valid = 1'b1; req1_a = 64'd6; req1_b = 64'd3; req1_fn = 2'd3;
      exp_g = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_ready0", req0_ready, !exp_g);
         chk("rr_ready1", req1_ready, exp_g);
         step();
         chk("rr_exec_rdy", {req0_ready, req1_ready}, 2'b00);
         step();
         chk("rr_valid", resp_valid, 1'b1);
         chk("rr_id", resp_id, exp_g);
         chk("rr_out", resp_out, exp_g ? 64'd5 : 64'd2);
         resp_ready = 1'b1;
         step();
         resp_ready = 1'b0;
         exp_g = !exp_g;
      end

      // hold result for 5 cycles with back-pressure
      #1;
      chk("hold_grant0", req0_ready, 1'b1);
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", resp_valid, 1'b1);
         chk("hold_out", resp_out, 64'd2);
         chk("hold_id", resp_id, 1'b0);
         chk("hold_rdy", {req0_ready, req1_ready}, 2'b00);
         step();
      end
      chk("hold_valid_end", resp_valid, 1'b1);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("release_grant1", req1_ready, 1'b1);
      chk("release_grant0", req0_ready, 1'b0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("drop_rdy", {req0_ready, req1_ready}, 2'b00);
      step();
      chk("drop_noop", resp_valid, 1'b0);
      step();
      chk("drop_noop2", resp_valid, 1'b0);

      // reset during EXEC abandons the result
      req0_valid = 1'b1; req0_a = 64'hFF; req0_b = 64'h0F; req0_fn = 2'd3;
      #1;
      chk("xor_ready", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_valid", resp_valid, 1'b0);
      chk("abort_out", resp_out, 64'd0);
      chk("abort_cc", resp_cc, 3'b000);
      chk("abort_id", resp_id, 1'b0);
      step();
      chk("abort_valid2", resp_valid, 1'b0);
      do_op(1'b1, 64'd2, 64'd3, 2'd0, 64'd5, 3'b000, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
